// File: rtl/if_fetch_stage_if.sv
// Bus bundle between the fetch stage, the ID stage, the stall controller and the
// instruction SRAM read port.
interface if_fetch_stage_if #(
    parameter int STALL_W = 6
);
    logic [STALL_W-1:0] stall;
    logic [32:0]        br_bus;          // {br_e, br_addr}
    logic [32:0]        if_to_id_bus;    // {ce, pc}
    logic               if_excp_adel;
    logic               inst_sram_en;
    logic [3:0]         inst_sram_wen;
    logic [31:0]        inst_sram_addr;
    logic [31:0]        inst_sram_wdata;

    // Fetch stage side
    modport master (
        input  stall, br_bus,
        output if_to_id_bus, if_excp_adel,
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
    );

    // ID / stall controller / SRAM side
    modport slave (
        output stall, br_bus,
        input  if_to_id_bus, if_excp_adel,
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, SRAM read port drive, and a held redirect
// so a taken branch arriving during a PC stall is not lost.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
    input  logic          clk,
    input  logic          rst,
    if_fetch_stage_if.master bus
);
    logic [31:0] pc_q, pc_d;
    logic        ce_q, ce_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] pend_addr_q, pend_addr_d;

    logic        br_e;
    logic [31:0] br_addr;
    logic [31:0] next_pc;
    logic        stop_pc;
    logic        misaligned;
    logic        unused_stall_hi;

    assign br_e    = bus.br_bus[32];
    assign br_addr = bus.br_bus[31:0];
    assign stop_pc = bus.stall[0];

    // Only bit 0 concerns the PC; the rest belong to later stages.
    assign unused_stall_hi = ^bus.stall;

    // A fresh branch beats an older held redirect.
    assign next_pc = br_e ? br_addr : (pend_v_q ? pend_addr_q : pc_q + 32'd4);

    always_comb begin
        pc_d        = pc_q;
        ce_d        = ce_q;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        if (!stop_pc) begin
            pc_d     = next_pc;
            ce_d     = 1'b1;
            pend_v_d = 1'b0;
        end else if (br_e) begin
            pend_v_d    = 1'b1;
            pend_addr_d = br_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            ce_q        <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_addr_q <= 32'd0;
        end else begin
            pc_q        <= pc_d;
            ce_q        <= ce_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    // Misaligned PC keeps advancing; the SRAM access is just suppressed.
    assign misaligned          = ce_q & (pc_q[1:0] != 2'b00);
    assign bus.if_excp_adel    = misaligned;
    assign bus.inst_sram_en    = ce_q & ~misaligned;
    assign bus.inst_sram_wen   = 4'b0000;
    assign bus.inst_sram_addr  = pc_q;
    assign bus.inst_sram_wdata = 32'd0;
    assign bus.if_to_id_bus    = {ce_q, pc_q};
endmodule
